// File: rtl/axil_lb_responder_if.sv
// AXI4-Lite slave channel plus local-bus signals for the PS-to-PL register responder.
// The slave modport is the responder's view; master is the PS/decoder side.
interface axil_lb_responder_if #(
  parameter int unsigned AXI_AW = 20,
  parameter int unsigned DW     = 32,
  parameter int unsigned LB_AW  = 18
);
  logic [AXI_AW-1:0] s_awaddr;
  logic              s_awvalid;
  logic              s_awready;
  logic [DW-1:0]     s_wdata;
  logic [DW/8-1:0]   s_wstrb;
  logic              s_wvalid;
  logic              s_wready;
  logic [1:0]        s_bresp;
  logic              s_bvalid;
  logic              s_bready;
  logic [AXI_AW-1:0] s_araddr;
  logic              s_arvalid;
  logic              s_arready;
  logic [DW-1:0]     s_rdata;
  logic [1:0]        s_rresp;
  logic              s_rvalid;
  logic              s_rready;
  logic [LB_AW-1:0]  lb_addr;
  logic [DW-1:0]     lb_wdata;
  logic [DW/8-1:0]   lb_wstrb;
  logic              lb_write;
  logic              lb_read;
  logic [DW-1:0]     lb_rdata;

  modport slave (
    input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
           s_araddr, s_arvalid, s_rready, lb_rdata,
    output s_awready, s_wready, s_bresp, s_bvalid, s_arready,
           s_rdata, s_rresp, s_rvalid,
           lb_addr, lb_wdata, lb_wstrb, lb_write, lb_read
  );

  modport master (
    output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
           s_araddr, s_arvalid, s_rready, lb_rdata,
    input  s_awready, s_wready, s_bresp, s_bvalid, s_arready,
           s_rdata, s_rresp, s_rvalid,
           lb_addr, lb_wdata, lb_wstrb, lb_write, lb_read
  );
endinterface

// File: rtl/axil_lb_responder.sv
// AXI4-Lite responder: turns each PS read/write into one local-bus strobe in the PL domain.
// One transaction in flight; round-robin between read and write when both arrive together.
module axil_lb_responder #(
  parameter int unsigned AXI_AW     = 20,
  parameter int unsigned DW         = 32,
  parameter int unsigned LB_AW      = 18,
  parameter int unsigned RD_LATENCY = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  axil_lb_responder_if.slave   bus
);
  localparam int unsigned SW = DW / 8;
  localparam int unsigned CW = 4;

  typedef enum logic [2:0] {
    IDLE, WR_COLLECT, WR_ISSUE, WR_RESP, RD_WAIT, RD_RESP
  } state_t;

  state_t           state, state_n;
  logic             rr_pri;
  logic             aw_got, w_got;
  logic [LB_AW-1:0] aw_q;
  logic [DW-1:0]    w_q;
  logic [SW-1:0]    strb_q;
  logic [CW-1:0]    rd_cnt;

  logic [LB_AW-1:0] lb_addr_q;
  logic [DW-1:0]    lb_wdata_q;
  logic [SW-1:0]    lb_wstrb_q;
  logic             lb_write_q, lb_read_q;
  logic             bvalid_q, rvalid_q;
  logic [DW-1:0]    rdata_q;

  logic awready_c, wready_c, arready_c;
  logic aw_hs, w_hs, ar_hs;
  logic wr_elig, rd_elig, toggle_pri;

  // Only the word-address bits reach the local bus; the rest are dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.s_awaddr, bus.s_araddr};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // Ready arbitration and next-state decode.
  always_comb begin
    state_n    = state;
    awready_c  = 1'b0;
    wready_c   = 1'b0;
    arready_c  = 1'b0;
    toggle_pri = 1'b0;
    wr_elig    = bus.s_awvalid | bus.s_wvalid;
    rd_elig    = bus.s_arvalid;

    case (state)
      IDLE: if (!reset) begin
        awready_c  = !(wr_elig && rd_elig && rr_pri);
        wready_c   = awready_c;
        arready_c  = !(wr_elig && rd_elig && !rr_pri);
        toggle_pri = wr_elig && rd_elig;
      end
      WR_COLLECT: begin
        awready_c = !aw_got;
        wready_c  = !w_got;
      end
      default: ;
    endcase

    aw_hs = bus.s_awvalid && awready_c;
    w_hs  = bus.s_wvalid  && wready_c;
    ar_hs = bus.s_arvalid && arready_c;

    case (state)
      IDLE: begin
        if (ar_hs)               state_n = RD_WAIT;
        else if (aw_hs && w_hs)  state_n = WR_ISSUE;
        else if (aw_hs || w_hs)  state_n = WR_COLLECT;
      end
      WR_COLLECT: if ((aw_got || aw_hs) && (w_got || w_hs)) state_n = WR_ISSUE;
      WR_ISSUE:   state_n = WR_RESP;
      WR_RESP:    if (bus.s_bready) state_n = IDLE;
      RD_WAIT:    if (rd_cnt == '0) state_n = RD_RESP;
      RD_RESP:    if (bus.s_rready) state_n = IDLE;
      default:    state_n = IDLE;
    endcase
  end

  // Channel capture, local-bus strobes and registered responses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_pri     <= 1'b0;
      aw_got     <= 1'b0;
      w_got      <= 1'b0;
      aw_q       <= '0;
      w_q        <= '0;
      strb_q     <= '0;
      rd_cnt     <= '0;
      lb_addr_q  <= '0;
      lb_wdata_q <= '0;
      lb_wstrb_q <= '0;
      lb_write_q <= 1'b0;
      lb_read_q  <= 1'b0;
      bvalid_q   <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
    end else begin
      if (toggle_pri) rr_pri <= !rr_pri;

      if (aw_hs) aw_q <= bus.s_awaddr[LB_AW+1:2];
      if (w_hs) begin
        w_q    <= bus.s_wdata;
        strb_q <= bus.s_wstrb;
      end

      if (state_n == WR_ISSUE) begin
        aw_got     <= 1'b0;
        w_got      <= 1'b0;
        lb_addr_q  <= aw_hs ? bus.s_awaddr[LB_AW+1:2] : aw_q;
        lb_wdata_q <= w_hs  ? bus.s_wdata : w_q;
        lb_wstrb_q <= w_hs  ? bus.s_wstrb : strb_q;
      end else begin
        if (aw_hs) aw_got <= 1'b1;
        if (w_hs)  w_got  <= 1'b1;
      end

      if (ar_hs) begin
        lb_addr_q <= bus.s_araddr[LB_AW+1:2];
        rd_cnt    <= CW'(RD_LATENCY - 1);
      end else if (state == RD_WAIT && rd_cnt != '0) begin
        rd_cnt <= rd_cnt - CW'(1);
      end

      if (state == RD_WAIT && rd_cnt == '0) rdata_q <= bus.lb_rdata;

      lb_write_q <= (state_n == WR_ISSUE);
      lb_read_q  <= ar_hs;
      bvalid_q   <= (state_n == WR_RESP);
      rvalid_q   <= (state_n == RD_RESP);
    end
  end

  assign bus.s_awready = awready_c;
  assign bus.s_wready  = wready_c;
  assign bus.s_arready = arready_c;
  assign bus.s_bvalid  = bvalid_q;
  assign bus.s_bresp   = 2'b00;
  assign bus.s_rvalid  = rvalid_q;
  assign bus.s_rresp   = 2'b00;
  assign bus.s_rdata   = rdata_q;
  assign bus.lb_addr   = lb_addr_q;
  assign bus.lb_wdata  = lb_wdata_q;
  assign bus.lb_wstrb  = lb_wstrb_q;
  assign bus.lb_write  = lb_write_q;
  assign bus.lb_read   = lb_read_q;
endmodule
